obstacle_spawner: RTL and testbench

- Consumes the 5-bit pseudo-random word from the `random` generator and turns it into timed spawn requests for the game's obstacle/draw engine.
- Waits a randomised number of game ticks, then picks a random lane (never the same lane twice in a row).
- Presents the lane on a valid/ready handshake and counts completed spawns.

---
 rtl/obstacle_spawner_pkg.sv | 21 ++
 rtl/obstacle_spawner_lane_mapper.sv | 35 +++
 rtl/obstacle_spawner.sv | 114 +++++++++++
 tb/tb_obstacle_spawner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_spawner_pkg.sv
// Shared game constants and the spawner state encoding.
// Pure declarations, no logic and no latency.
// No handshake; imported by the spawner and the draw engine.
package obstacle_spawner_pkg;

  localparam int LANE_W           = 3;
  localparam int RAND_W           = 5;
  localparam int NUM_COLS_DEFAULT = 5;

  // Marker for "no lane spawned yet": never matches a real lane (max 7 only when NUM_COLS=8
  // would make lane 7 legal, which is the one case where the first spawn may be nudged).
  localparam logic [LANE_W-1:0] NO_LANE = 3'h7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PICK = 2'd2,
    REQ  = 2'd3
  } spawn_state_t;

endpackage

// File: rtl/obstacle_spawner_lane_mapper.sv
// Folds a raw 3-bit random value into a legal lane, stepping past the previous lane.
// Purely combinational, zero latency.
// No handshake; result is consumed by the spawner in its PICK cycle.
module lane_mapper
  import obstacle_spawner_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEFAULT
) (
  input  logic [LANE_W-1:0] raw,
  input  logic [LANE_W-1:0] last_lane,
  output logic [LANE_W-1:0] lane
);

  // One extra bit so NUM_COLS=8 is representable in the fold comparison.
  localparam logic [LANE_W:0]   NC       = (LANE_W+1)'(NUM_COLS);
  localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(NUM_COLS - 1);

  logic [LANE_W:0]   raw_ext;
  logic [LANE_W-1:0] folded;

  assign raw_ext = {1'b0, raw};

  // Fold out-of-range values back into range, then bump past a repeat of the last lane.
  always_comb begin
    folded = raw;
    if (raw_ext >= NC) begin
      folded = LANE_W'(raw_ext - NC);
    end
    lane = folded;
    if (folded == last_lane) begin
      lane = (folded == TOP_LANE) ? '0 : folded + 1'b1;
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Turns the random word into timed, lane-randomised obstacle spawn requests.
// Spawn_valid rises two clks after the tick that exhausts the gap; accept completes the cycle after.
// Request is held with a stable lane until spawn_ready; ticks arriving meanwhile are dropped.
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEFAULT,
  parameter int MIN_GAP  = 2,
  parameter int GAP_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [RAND_W-1:0] rand_num,
  input  logic              enable,
  input  logic              tick,
  input  logic              spawn_ready,
  output logic              spawn_valid,
  output logic [LANE_W-1:0] spawn_lane,
  output logic [7:0]        spawn_count,
  output logic              busy
);

  spawn_state_t      state;
  spawn_state_t      state_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_load;
  logic [LANE_W-1:0] last_lane;
  logic [LANE_W-1:0] lane_pick;
  logic              accept;
  logic              load_gap;
  logic              gap_done;

  // Gap of MIN_GAP..MIN_GAP+3 ticks drawn from the top two random bits.
  assign gap_load = GAP_W'(MIN_GAP) + GAP_W'(rand_num[4:3]);

  // spawn_valid is always high in REQ, so REQ with ready is the handshake.
  assign accept   = (state == REQ) && spawn_ready;
  assign gap_done = (gap_cnt == GAP_W'(1));
  assign load_gap = enable && ((state == IDLE) || accept);
  assign busy     = (state != IDLE);

  lane_mapper #(
    .NUM_COLS (NUM_COLS)
  ) u_lane_mapper (
    .raw       (rand_num[LANE_W-1:0]),
    .last_lane (last_lane),
    .lane      (lane_pick)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: abort beats tick in WAIT; PICK is a single cycle; REQ waits for ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = WAIT;
      WAIT: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (tick && gap_done) begin
          state_nxt = PICK;
        end
      end
      PICK: state_nxt = REQ;
      REQ:  if (spawn_ready) state_nxt = enable ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gap counter: reload on entry to WAIT, count down one per tick until the last one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap_cnt <= '0;
    end else if (load_gap) begin
      gap_cnt <= gap_load;
    end else if ((state == WAIT) && enable && tick && !gap_done) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Request register: lane latched in PICK and frozen until the handshake completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spawn_valid <= 1'b0;
      spawn_lane  <= '0;
    end else if (state == PICK) begin
      spawn_valid <= 1'b1;
      spawn_lane  <= lane_pick;
    end else if (accept) begin
      spawn_valid <= 1'b0;
    end
  end

  // Accepted-spawn bookkeeping: remember the lane for repeat avoidance, count with saturation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_lane   <= NO_LANE;
      spawn_count <= '0;
    end else if (accept) begin
      last_lane <= spawn_lane;
      if (spawn_count != 8'hFF) begin
        spawn_count <= spawn_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: scoreboard of expected spawns checked on every handshake.
// Stimulus drives inputs 1 time unit after posedge; the monitor samples on negedge.
// Covers latency, repeat avoidance, backpressure, enable handling, saturation and async reset.
module tb_obstacle_spawner;

  localparam int MIN_GAP = 2;

  logic       clk;
  logic       resetn;
  logic [4:0] rand_num;
  logic       enable;
  logic       tick;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [2:0] spawn_lane;
  logic [7:0] spawn_count;
  logic       busy;

  typedef struct {
    int lane;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_total   = 0;
  int   n_pass    = 0;
  int   exp_count = 0;
  int   next_gap  = 0;

  obstacle_spawner #(
    .NUM_COLS (5),
    .MIN_GAP  (MIN_GAP),
    .GAP_W    (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rand_num    (rand_num),
    .enable      (enable),
    .tick        (tick),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_count (spawn_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic lvl, input string nm);
    int k;
    k = 0;
    while (spawn_valid !== lvl && k < 16) begin
      cyc(1);
      k++;
    end
    check(nm, int'(spawn_valid), int'(lvl));
  endtask

  task automatic tick_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
  endtask

  // Full spawn from WAIT with ready high; gap taken from the previous load.
  task automatic spawn_run(input logic [4:0] r, input int exp_lane);
    exp_t e;
    rand_num = r;
    e.lane = exp_lane;
    e.cnt  = exp_count;
    sb_q.push_back(e);
    tick_pulses(next_gap);
    wait_valid(1'b1, "spawn_valid_rise");
    wait_valid(1'b0, "spawn_valid_fall");
    exp_count = (exp_count >= 255) ? 255 : exp_count + 1;
    next_gap  = MIN_GAP + int'(r[4:3]);
  endtask

  // Monitor: every handshake must match the oldest expected spawn.
  always @(negedge clk) begin
    if (resetn && spawn_valid && spawn_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_spawn: got lane %0d, expected no request", spawn_lane);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_lane", int'(spawn_lane), e.lane);
        check("sb_count_before_accept", int'(spawn_count), e.cnt);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    resetn      = 1'b0;
    rand_num    = '0;
    enable      = 1'b0;
    tick        = 1'b0;
    spawn_ready = 1'b0;
    cyc(2);
    check("reset_valid", int'(spawn_valid), 0);
    check("reset_lane",  int'(spawn_lane), 0);
    check("reset_count", int'(spawn_count), 0);
    check("reset_busy",  int'(busy), 0);
    resetn = 1'b1;
    cyc(1);

    // Gap 3 from rand 01110, lane 6-5=1, exact latency.
    rand_num    = 5'b01110;
    enable      = 1'b1;
    spawn_ready = 1'b1;
    cyc(1);
    check("busy_after_enable", int'(busy), 1);
    begin
      exp_t e;
      e.lane = 1;
      e.cnt  = 0;
      sb_q.push_back(e);
    end
    tick_pulses(2);
    check("valid_before_3rd_tick", int'(spawn_valid), 0);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("valid_in_pick", int'(spawn_valid), 0);
    cyc(1);
    check("valid_in_req", int'(spawn_valid), 1);
    check("lane_in_req", int'(spawn_lane), 1);
    cyc(1);
    check("valid_one_clk", int'(spawn_valid), 0);
    check("count_after_first", int'(spawn_count), 1);
    check("busy_reloaded", int'(busy), 1);
    exp_count = 1;
    next_gap  = 3;

    // Repeat avoidance and folding.
    spawn_run(5'b00001, 2);  // last 1, raw 1 -> 2
    spawn_run(5'b00100, 4);  // last 2, raw 4 -> 4
    spawn_run(5'b00100, 0);  // last 4, raw 4 -> wrap to 0
    spawn_run(5'b00101, 1);  // last 0, raw 5 folds to 0 -> 1
    spawn_run(5'b00111, 2);  // last 1, raw 7 folds to 2

    // Backpressure: last 2, raw 2 -> 3; lane must not follow rand_num while held.
    spawn_ready = 1'b0;
    rand_num    = 5'b00010;
    begin
      exp_t e;
      e.lane = 3;
      e.cnt  = exp_count;
      sb_q.push_back(e);
    end
    tick_pulses(next_gap);
    wait_valid(1'b1, "bp_valid_rise");
    begin
      int stable;
      stable = 0;
      for (int i = 0; i < 10; i++) begin
        tick     = (i % 2 == 0);
        rand_num = 5'(i + 3);
        cyc(1);
        if (spawn_valid === 1'b1 && spawn_lane === 3'd3 && int'(spawn_count) == exp_count)
          stable++;
      end
      check("bp_stable_cycles", stable, 10);
    end
    tick        = 1'b0;
    rand_num    = 5'b00010;
    spawn_ready = 1'b1;
    cyc(1);
    check("bp_valid_after_accept", int'(spawn_valid), 0);
    check("bp_count_after_accept", int'(spawn_count), exp_count + 1);
    exp_count++;

    // Enable drop in WAIT, then tick coinciding with enable drop.
    enable = 1'b0;
    cyc(1);
    check("abort_wait_busy", int'(busy), 0);
    enable = 1'b1;
    cyc(1);
    check("reenable_busy", int'(busy), 1);
    tick_pulses(1);
    cyc(2);
    check("hold_without_tick", int'(spawn_valid), 0);
    tick   = 1'b1;
    enable = 1'b0;
    cyc(1);
    tick = 1'b0;
    check("abort_beats_tick_busy", int'(busy), 0);
    cyc(2);
    check("abort_beats_tick_valid", int'(spawn_valid), 0);

    // Enable drop in REQ: last 3, raw 0 -> 0; request held, then IDLE with no reload.
    rand_num    = 5'b00000;
    enable      = 1'b1;
    spawn_ready = 1'b0;
    cyc(1);
    begin
      exp_t e;
      e.lane = 0;
      e.cnt  = exp_count;
      sb_q.push_back(e);
    end
    tick_pulses(2);
    wait_valid(1'b1, "req_enable_valid_rise");
    enable = 1'b0;
    cyc(3);
    check("req_held_after_enable_drop", int'(spawn_valid), 1);
    spawn_ready = 1'b1;
    cyc(1);
    check("req_disabled_valid_low", int'(spawn_valid), 0);
    check("req_disabled_busy", int'(busy), 0);
    check("req_disabled_count", int'(spawn_count), exp_count + 1);
    exp_count++;
    cyc(2);
    check("req_disabled_no_reload", int'(busy), 0);

    // Async reset while a request is pending: last 0, raw 0 -> 1.
    rand_num    = 5'b00000;
    enable      = 1'b1;
    spawn_ready = 1'b0;
    cyc(1);
    tick_pulses(2);
    wait_valid(1'b1, "pre_reset_valid_rise");
    check("pre_reset_lane", int'(spawn_lane), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_valid", int'(spawn_valid), 0);
    check("async_reset_count", int'(spawn_count), 0);
    check("async_reset_busy",  int'(busy), 0);
    check("async_reset_lane",  int'(spawn_lane), 0);
    enable      = 1'b0;
    spawn_ready = 1'b1;
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    exp_count = 0;

    // First spawn after reset: raw 0 equals the pre-reset last lane but must not be bumped.
    enable = 1'b1;
    cyc(1);
    next_gap = 2;
    spawn_run(5'b00000, 0);

    // Saturation: raw 0 alternates lanes 1,0,1,0...
    for (int i = 0; i < 260; i++) begin
      spawn_run(5'b00000, (i % 2 == 0) ? 1 : 0);
    end
    check("count_saturated", int'(spawn_count), 255);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
